fp_div_core: RTL and testbench
==============================

FP_DIV_CORE -- requirements
Module: fp_div_core

Interface
REQ-001 Parameter BUS_WIDTH, default 32, SHALL be the operand/result width (IEEE-754 single precision only).
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset; reset is asynchronous and active-low.
REQ-004 start  input  1  SHALL request a division; sampled only in IDLE.
REQ-005 data_iA  input  BUS_WIDTH  SHALL be the dividend, captured on the accepted start.
REQ-006 data_iB  input  BUS_WIDTH  SHALL be the divisor, captured on the accepted start.
REQ-007 busy  output  1  SHALL be high whenever state is not IDLE.
REQ-008 done  output  1  SHALL pulse high for one cycle when data_o is newly valid.
REQ-009 data_o  output  BUS_WIDTH  SHALL be the raw quotient, i.e. the data_o_i input of the special-case output stage.

Function
REQ-010 FSM states IDLE, ITER, NORM, DONE; IDLE->ITER on start, ITER->NORM when iteration counter reaches 25, NORM->DONE, DONE->IDLE unconditionally.
REQ-011 The accepted start SHALL latch sign = A[31]^B[31], exponent = A[30:23]-B[30:23]+127 (10-bit signed), mantissas {1,A[22:0]} and {1,B[22:0]}.
REQ-012 ITER SHALL perform one restoring-division step per cycle, producing 26 quotient bits q[25:0] MSB first over exactly 26 cycles; 5-bit counter 0..25.
REQ-013 NORM: if q[25]=1, mantissa = q[25:2], guard = q[1], sticky = q[0] | (remainder != 0); else mantissa = q[24:1], guard = q[0], sticky = (remainder != 0), exponent decremented by 1.
REQ-014 Rounding carry out of the 24-bit mantissa SHALL set mantissa to 1.0 and increment exponent by 1.
REQ-015 Final exponent >= 255 SHALL yield {sign, 8'hFF, 23'd0}; final exponent <= 0 SHALL yield {sign, 31'd0}; no subnormal outputs.
REQ-016 done SHALL go high exactly 28 rising edges after the edge that accepted start; busy high for those 28 cycles plus the done cycle.
REQ-017 data_o SHALL update only on the NORM->DONE edge and hold until the next result.
REQ-018 start while busy SHALL be ignored with no effect on the operation in progress; start held high through DONE SHALL be accepted on the first IDLE cycle.
REQ-019 Zero, infinity and NaN operands need no special handling; the downstream output stage overrides them; exponent fields are used as-is.

Reset
REQ-020 rst_n low SHALL immediately force state IDLE, busy 0, done 0, data_o 0, counter 0, all datapath registers 0, including mid-operation; the operation is discarded.
REQ-021 After rst_n rises, the first start SHALL be accepted normally.

Configuration
REQ-022 With FP_DIV_ROUND_EN defined, NORM SHALL round to nearest even (increment if guard & (sticky | mantissa[0])).
REQ-023 Without FP_DIV_ROUND_EN, NORM SHALL truncate (guard and sticky ignored); latency unchanged.

Structure
REQ-024 Shared package: exponent bias 127, mantissa width 23, quotient bit count 26, FSM state encoding, infinity/zero constants.
REQ-025 One sub-module fp_div_step SHALL implement a single combinational restoring step (partial remainder, divisor -> next remainder, quotient bit); all registers in fp_div_core.

Verification
REQ-026 A=0x40C00000 (6.0), B=0x40000000 (2.0) -> data_o=0x40400000, done 28 cycles after start.
REQ-027 A=0x3F800000, B=0x40400000 (1/3) -> 0x3EAAAAAB with FP_DIV_ROUND_EN, 0x3EAAAAAA without.
REQ-028 A=0xBF800000, B=0x3F000000 -> 0xC0000000; A=0x7F000000, B=0x00800000 -> 0x7F800000 (overflow); A=0x00800000, B=0x7F000000 -> 0x00000000 (underflow).
REQ-029 Second start with different operands 5 cycles into an operation -> ignored; first result delivered unchanged at cycle 28; busy never drops early.
REQ-030 rst_n pulsed low at cycle 10 of an operation -> busy, done, data_o 0 immediately; no done afterwards; a new start then yields a correct result 28 cycles later.

Source files
------------

// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared constants and types for the single-precision divider.
//   EXP_BIAS / MANT_W / Q_BITS : IEEE-754 single-precision field sizes and
//                                 the number of quotient bits produced
//   EXP_W                      : width of the signed working exponent
//   state_t                    : divider FSM state encoding
//   MAG_INF / MAG_ZERO         : magnitude fields for overflow/underflow
package fp_div_pkg;

    localparam int EXP_BIAS = 127;
    localparam int MANT_W   = 23;
    localparam int Q_BITS   = 26;
    localparam int EXP_W    = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [30:0] MAG_INF  = {8'hFF, 23'd0};
    localparam logic [30:0] MAG_ZERO = 31'd0;

endpackage

// File: rtl/fp_div_if.sv
// fp_div_if: request/result bundle of the divider.
//   start    : request a division (master -> slave)
//   data_iA  : dividend          (master -> slave)
//   data_iB  : divisor           (master -> slave)
//   busy     : divider not idle  (slave -> master)
//   done     : one-cycle result-valid pulse (slave -> master)
//   data_o   : raw quotient      (slave -> master)
interface fp_div_if #(
    parameter int BUS_WIDTH = 32
);
    logic                 start;
    logic [BUS_WIDTH-1:0] data_iA;
    logic [BUS_WIDTH-1:0] data_iB;
    logic                 busy;
    logic                 done;
    logic [BUS_WIDTH-1:0] data_o;

    modport master (
        output start, data_iA, data_iB,
        input  busy, done, data_o
    );

    modport slave (
        input  start, data_iA, data_iB,
        output busy, done, data_o
    );
endinterface

// File: rtl/fp_div_step.sv
// fp_div_step: one combinational restoring-division step.
//   i_rem : partial remainder (always < 2 * i_div)
//   i_div : divisor mantissa with hidden bit
//   o_rem : next partial remainder, already shifted left by one
//   o_q   : quotient bit produced by this step
module fp_div_step
    import fp_div_pkg::*;
(
    input  logic [MANT_W+1:0] i_rem,
    input  logic [MANT_W:0]   i_div,
    output logic [MANT_W+1:0] o_rem,
    output logic              o_q
);
    // When the subtraction succeeds the difference is below i_div, so the
    // low MANT_W+1 bits hold it exactly.
    logic [MANT_W:0] w_diff;

    assign o_q    = (i_rem >= {1'b0, i_div});
    assign w_diff = i_rem[MANT_W:0] - i_div;
    assign o_rem  = o_q ? {w_diff, 1'b0} : {i_rem[MANT_W:0], 1'b0};
endmodule

// File: rtl/fp_div_core.sv
// fp_div_core: IEEE-754 single-precision divider, restoring, one quotient
// bit per cycle. Result is the raw quotient; zero/inf/NaN operands are
// resolved by a downstream output stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fp_div_if slave (start, data_iA, data_iB, busy, done, data_o)
// Build option: define FP_DIV_ROUND_EN for round-to-nearest-even; the
// default build truncates. Latency is the same in both builds.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; operands captured on the accepting edge
// ITER    | 26 restoring steps, counter 0..25
// NORM    | cycle 0: normalise, pick rounding; cycle 1: round, clamp, write data_o
// DONE    | done pulse, return to IDLE
module fp_div_core
    import fp_div_pkg::*;
#(
    parameter int BUS_WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    fp_div_if.slave bus
);

`ifdef FP_DIV_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [4:0]              r_cnt;
    logic                    r_sign;
    logic signed [EXP_W-1:0] r_exp;
    logic [MANT_W:0]         r_div;
    logic [MANT_W+1:0]       r_rem;
    logic [Q_BITS-1:0]       r_q;
    logic [MANT_W-1:0]       r_frac;
    logic                    r_inc;
    logic [BUS_WIDTH-1:0]    r_data_o;

    logic [MANT_W+1:0]       w_rem_nxt;
    logic                    w_qbit;
    logic signed [EXP_W-1:0] w_exp_in;
    logic [MANT_W-1:0]       w_frac_n;
    logic                    w_guard;
    logic                    w_sticky;
    logic                    w_inc;
    logic [MANT_W:0]         w_frac_r;
    logic signed [EXP_W-1:0] w_exp_r;
    logic [BUS_WIDTH-1:0]    w_result;

    fp_div_step u_step (
        .i_rem (r_rem),
        .i_div (r_div),
        .o_rem (w_rem_nxt),
        .o_q   (w_qbit)
    );

    // Modulo-1024 arithmetic gives the correct signed biased exponent.
    assign w_exp_in = signed'({2'b00, bus.data_iA[30:23]} - {2'b00, bus.data_iB[30:23]}
                              + EXP_W'(EXP_BIAS));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_nxt = ST_ITER;
            ST_ITER: if (r_cnt == 5'(Q_BITS - 1)) w_state_nxt = ST_NORM;
            ST_NORM: if (r_cnt == 5'd1) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Quotient lies in (0.5, 2): q[25] is the integer bit.
    always_comb begin
        w_frac_n = r_q[Q_BITS-3:1];
        w_guard  = r_q[0];
        w_sticky = (r_rem != '0);
        if (r_q[Q_BITS-1]) begin
            w_frac_n = r_q[Q_BITS-2:2];
            w_guard  = r_q[1];
            w_sticky = r_q[0] | (r_rem != '0);
        end
        w_inc = ROUND_EN & w_guard & (w_sticky | w_frac_n[0]);
    end

    // A carry out of an all-ones fraction leaves the fraction zero, which is
    // exactly mantissa 1.0 at the next exponent.
    always_comb begin
        w_frac_r = {1'b0, r_frac} + {{MANT_W{1'b0}}, r_inc};
        w_exp_r  = w_frac_r[MANT_W] ? r_exp + 10'sd1 : r_exp;
        if (w_exp_r >= 10'sd255) begin
            w_result = {r_sign, MAG_INF};
        end else if (w_exp_r <= 10'sd0) begin
            w_result = {r_sign, MAG_ZERO};
        end else begin
            w_result = {r_sign, w_exp_r[7:0], w_frac_r[MANT_W-1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_div    <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_frac   <= '0;
            r_inc    <= 1'b0;
            r_data_o <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_cnt  <= '0;
                        r_sign <= bus.data_iA[31] ^ bus.data_iB[31];
                        r_exp  <= w_exp_in;
                        r_div  <= {1'b1, bus.data_iB[MANT_W-1:0]};
                        r_rem  <= {2'b01, bus.data_iA[MANT_W-1:0]};
                        r_q    <= '0;
                        r_frac <= '0;
                        r_inc  <= 1'b0;
                    end
                end
                ST_ITER: begin
                    r_rem <= w_rem_nxt;
                    r_q   <= {r_q[Q_BITS-2:0], w_qbit};
                    r_cnt <= (r_cnt == 5'(Q_BITS - 1)) ? 5'd0 : r_cnt + 5'd1;
                end
                ST_NORM: begin
                    if (r_cnt == 5'd0) begin
                        r_frac <= w_frac_n;
                        r_inc  <= w_inc;
                        if (!r_q[Q_BITS-1]) r_exp <= r_exp - 10'sd1;
                        r_cnt  <= 5'd1;
                    end else begin
                        r_data_o <= w_result;
                        r_cnt    <= 5'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (r_state != ST_IDLE);
    assign bus.done   = (r_state == ST_DONE);
    assign bus.data_o = r_data_o;

endmodule

// File: tb/tb_fp_div_core.sv
// tb_fp_div_core: directed vector table plus hand-written sequences for the
// divider: busy-start rejection, start held through DONE, mid-operation reset.
module tb_fp_div_core;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fp_div_if #(.BUS_WIDTH(32)) bus ();

    fp_div_core #(.BUS_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef FP_DIV_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q_rne;
        logic [31:0] q_trn;
    } vec_t;

    localparam int N_VEC = 18;
    vec_t vecs [N_VEC];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string what, input int idx,
                         input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s [%0d]: got %08h, want %08h", what, idx, act, req);
        end
    endtask

    // One division with a single-cycle start; latency counts edges after the
    // accepting edge until done is seen.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output bit busy_ok);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_iA = a;
        bus.data_iB = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy_ok   = bus.busy;
        lat       = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        res = bus.data_o;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] res;
        logic [31:0] res1;
        int          lat;
        int          first;
        int          second;
        int          n_done;
        bit          bok;
        bit          idle_gap;

        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000}; // 6/2
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 32'h3EAAAAAA}; // 1/3
        vecs[2]  = '{32'hBF800000, 32'h3F000000, 32'hC0000000, 32'hC0000000}; // -1/0.5
        vecs[3]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, 32'h7F800000}; // overflow
        vecs[4]  = '{32'h00800000, 32'h7F000000, 32'h00000000, 32'h00000000}; // underflow
        vecs[5]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000}; // 1/1
        vecs[6]  = '{32'h40E00000, 32'h40000000, 32'h40600000, 32'h40600000}; // 7/2
        vecs[7]  = '{32'h40000000, 32'h40400000, 32'h3F2AAAAB, 32'h3F2AAAAA}; // 2/3
        vecs[8]  = '{32'h3F800000, 32'h41200000, 32'h3DCCCCCD, 32'h3DCCCCCC}; // 1/10
        vecs[9]  = '{32'hC0C00000, 32'hC0000000, 32'h40400000, 32'h40400000}; // -6/-2
        vecs[10] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 32'h7F000000}; // exp 254
        vecs[11] = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 32'h7F800000}; // exp 255
        vecs[12] = '{32'h00800000, 32'h3F800000, 32'h00800000, 32'h00800000}; // exp 1
        vecs[13] = '{32'h00800000, 32'h40000000, 32'h00000000, 32'h00000000}; // exp 0
        vecs[14] = '{32'h00800000, 32'h3FC00000, 32'h00000000, 32'h00000000}; // norm to 0
        vecs[15] = '{32'hFF000000, 32'h00800000, 32'hFF800000, 32'hFF800000}; // -overflow
        vecs[16] = '{32'h80800000, 32'h7F000000, 32'h80000000, 32'h80000000}; // -underflow
        vecs[17] = '{32'h40A00000, 32'h40400000, 32'h3FD55555, 32'h3FD55555}; // 5/3

        bus.start   = 1'b0;
        bus.data_iA = '0;
        bus.data_iB = '0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 0, {31'd0, bus.busy}, 32'd0);
        check("reset done", 0, {31'd0, bus.done}, 32'd0);
        check("reset data_o", 0, bus.data_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < N_VEC; i++) begin
            do_op(vecs[i].a, vecs[i].b, res, lat, bok);
            check("result", i, res, ROUND_EN ? vecs[i].q_rne : vecs[i].q_trn);
            check("latency", i, 32'(lat), 32'd28);
            check("busy held", i, {31'd0, bok}, 32'd1);
            @(posedge clk); #1;
            check("idle after done", i, {30'd0, bus.busy, bus.done}, 32'd0);
            check("data_o hold", i, bus.data_o, ROUND_EN ? vecs[i].q_rne : vecs[i].q_trn);
        end

        // start while busy is ignored
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_iA = 32'h40C00000;
        bus.data_iB = 32'h40000000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        bok = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 5) begin
                bus.start   = 1'b1;
                bus.data_iA = 32'h3F800000;
                bus.data_iB = 32'h40400000;
            end
            if (n == 6) bus.start = 1'b0;
            if (!bus.busy) bok = 1'b0;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        check("busy-start result", 0, bus.data_o, 32'h40400000);
        check("busy-start latency", 0, 32'(lat), 32'd28);
        check("busy-start busy held", 0, {31'd0, bok}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("busy-start no restart", 0, {31'd0, bus.busy}, 32'd0);

        // start held high through DONE: accepted again on the first IDLE cycle
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_iA = 32'h40C00000;
        bus.data_iB = 32'h40000000;
        @(posedge clk); #1;
        first    = -1;
        second   = -1;
        res1     = '0;
        res      = '0;
        idle_gap = 1'b0;
        for (int n = 1; n <= 70; n++) begin
            @(posedge clk); #1;
            if (n == 29) begin
                idle_gap    = !bus.busy;
                bus.data_iA = 32'h40E00000;
                bus.data_iB = 32'h40000000;
            end
            if (bus.done) begin
                if (first < 0) begin
                    first = n;
                    res1  = bus.data_o;
                end else begin
                    second = n;
                    res    = bus.data_o;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        check("held-start first done", 0, 32'(first), 32'd28);
        check("held-start first result", 0, res1, 32'h40400000);
        check("held-start idle gap", 0, {31'd0, idle_gap}, 32'd1);
        check("held-start second done", 0, 32'(second), 32'd58);
        check("held-start second result", 0, res, 32'h40600000);
        repeat (3) @(posedge clk);

        // reset in the middle of an operation
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_iA = 32'h3F800000;
        bus.data_iB = 32'h41200000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pre-reset busy", 0, {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid-reset busy", 0, {31'd0, bus.busy}, 32'd0);
        check("mid-reset done", 0, {31'd0, bus.done}, 32'd0);
        check("mid-reset data_o", 0, bus.data_o, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        repeat (35) begin
            @(posedge clk); #1;
            if (bus.done) n_done++;
        end
        check("no done after reset", 0, 32'(n_done), 32'd0);
        do_op(32'h40C00000, 32'h40000000, res, lat, bok);
        check("post-reset result", 0, res, 32'h40400000);
        check("post-reset latency", 0, 32'(lat), 32'd28);
        check("post-reset busy held", 0, {31'd0, bok}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
